// File: rtl/stump_fetch_unit_pkg.sv
// Shared definitions for the Stump fetch stage: FSM state encoding, opcodes,
// branch condition codes, flag bit positions and the branch offset extender.
package stump_fetch_unit_pkg;

    // Control FSM states; 2'b11 is unused and treated as illegal.
    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        EXECUTE = 2'b01,
        MEMORY  = 2'b10
    } state_e;

    // Major opcodes held in ir[15:13].
    localparam logic [2:0] OP_LDST = 3'b011;
    localparam logic [2:0] OP_BCC  = 3'b111;

    // Branch condition field ir[11:8].
    typedef enum logic [3:0] {
        COND_AL = 4'h0, COND_NV = 4'h1, COND_HI = 4'h2, COND_LS = 4'h3,
        COND_CC = 4'h4, COND_CS = 4'h5, COND_NE = 4'h6, COND_EQ = 4'h7,
        COND_VC = 4'h8, COND_VS = 4'h9, COND_PL = 4'hA, COND_MI = 4'hB,
        COND_GE = 4'hC, COND_LT = 4'hD, COND_GT = 4'hE, COND_LE = 4'hF
    } cond_e;

    // Bit positions of the flags inside cc = {N,Z,V,C}.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    // Sign-extend an 8-bit branch offset to the 16-bit address width.
    function automatic logic [15:0] sext8(input logic [7:0] value);
        return {{8{value[7]}}, value};
    endfunction

endpackage

// File: rtl/stump_fetch_unit_if.sv
// Instruction fetch bus between the fetch unit (master) and memory (slave).
interface stump_fetch_unit_if;

    logic        fetch_en;
    logic [15:0] fetch_addr;
    logic [15:0] mem_rdata;

    modport master (output fetch_en, output fetch_addr, input mem_rdata);
    modport slave  (input fetch_en, input fetch_addr, output mem_rdata);

endinterface

// File: rtl/stump_fetch_unit_cond_eval.sv
// Stump branch condition evaluator: decides whether a Bcc condition holds
// for the current {N,Z,V,C} flags. Purely combinational.
module stump_cond_eval
    import stump_fetch_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] cc,
    output logic       true
);

    logic n, z, v, c;

    assign n = cc[FLAG_N];
    assign z = cc[FLAG_Z];
    assign v = cc[FLAG_V];
    assign c = cc[FLAG_C];

    // Condition table lookup.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        true = 1'b0;
        case (cond_e'(cond))
            COND_AL: true = 1'b1;
            COND_NV: true = 1'b0;
            COND_HI: true = !c && !z;
            COND_LS: true = c || z;
            COND_CC: true = !c;
            COND_CS: true = c;
            COND_NE: true = !z;
            COND_EQ: true = z;
            COND_VC: true = !v;
            COND_VS: true = v;
            COND_PL: true = !n;
            COND_MI: true = n;
            COND_GE: true = (n == v);
            COND_LT: true = (n != v);
            COND_GT: true = !z && (n == v);
            COND_LE: true = z || (n != v);
            default: true = 1'b0;
        endcase
    end

endmodule

// File: rtl/stump_fetch_unit.sv
// Stump fetch stage: owns pc and ir, issues instruction reads in FETCH and
// resolves Bcc branches in EXECUTE. Sequencing belongs to the control FSM.
module stump_fetch_unit
    import stump_fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                state,
    input  logic [3:0]                cc,
    input  logic                      pc_wr_en,
    input  logic [15:0]               pc_wr_data,
    stump_fetch_unit_if.master        bus,
    output logic [15:0]               ir,
    output logic [15:0]               pc,
    output logic                      branch_taken,
    output logic [15:0]               branch_target
);

    logic        cond_true;
    logic        is_bcc;
    logic [15:0] pc_next;

    stump_cond_eval u_cond_eval (
        .cond (ir[11:8]),
        .cc   (cc),
        .true (cond_true)
    );

    assign bus.fetch_en   = (state == FETCH);
    assign bus.fetch_addr = pc;

    // pc has already been incremented past the Bcc when EXECUTE runs.
    assign is_bcc        = (ir[15:13] == OP_BCC);
    assign branch_taken  = (state == EXECUTE) && is_bcc && cond_true;
    assign branch_target = pc + sext8(ir[7:0]);

    // Next-PC priority mux: increment in FETCH, branch over PC write in EXECUTE.
    always_comb begin
        pc_next = pc;
        case (state)
            FETCH:   pc_next = pc + 16'd1;
            EXECUTE: begin
                if (branch_taken) begin
                    pc_next = branch_target;
                end else if (pc_wr_en) begin
                    pc_next = pc_wr_data;
                end
            end
            MEMORY:  begin
                if (pc_wr_en) begin
                    pc_next = pc_wr_data;
                end
            end
            default: pc_next = pc;
        endcase
    end

    // pc and ir registers with asynchronous reset; ir loads only in FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
            ir <= 16'h0000;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            pc <= pc_next;
            if (state == FETCH) begin
                ir <= bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_stump_fetch_unit.sv
// Self-checking bench for stump_fetch_unit: directed stimulus, a spec-level
// reference model compared every cycle, and hand-computed literal checks.
module tb_stump_fetch_unit;

    import stump_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  state;
    logic [3:0]  cc;
    logic        pc_wr_en;
    logic [15:0] pc_wr_data;
    logic [15:0] ir;
    logic [15:0] pc;
    logic        branch_taken;
    logic [15:0] branch_target;

    stump_fetch_unit_if bus ();

    stump_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .state         (state),
        .cc            (cc),
        .pc_wr_en      (pc_wr_en),
        .pc_wr_data    (pc_wr_data),
        .bus           (bus),
        .ir            (ir),
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    // Which flag values {N,Z,V,C} = index make each condition true, worked out by hand.
    logic [15:0] cond_mask [16] = '{
        16'hFFFF, 16'h0000, 16'h0505, 16'hFAFA,
        16'h5555, 16'hAAAA, 16'h0F0F, 16'hF0F0,
        16'h3333, 16'hCCCC, 16'h00FF, 16'hFF00,
        16'hCC33, 16'h33CC, 16'h0C03, 16'hF3FC
    };

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    // Reference condition evaluation, straight from the condition table.
    function automatic logic cond_ref(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, v, c;
        n = f[3]; z = f[2]; v = f[1]; c = f[0];
        case (cond)
            4'h0: return 1'b1;
            4'h1: return 1'b0;
            4'h2: return !c && !z;
            4'h3: return c || z;
            4'h4: return !c;
            4'h5: return c;
            4'h6: return !z;
            4'h7: return z;
            4'h8: return !v;
            4'h9: return v;
            4'hA: return !n;
            4'hB: return n;
            4'hC: return n == v;
            4'hD: return n != v;
            4'hE: return !z && (n == v);
            default: return z || (n != v);
        endcase
    endfunction

    // Reference model state.
    logic [15:0] m_pc;
    logic [15:0] m_ir;

    function automatic logic m_taken();
        return (state == EXECUTE) && (m_ir[15:13] == 3'b111) && cond_ref(m_ir[11:8], cc);
    endfunction

    function automatic logic [15:0] m_target();
        int t;
        t = int'(m_pc) + int'($signed(m_ir[7:0]));
        return t[15:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc <= 16'h0000;
            m_ir <= 16'h0000;
        end else begin
            case (state)
                FETCH: begin
                    m_ir <= bus.mem_rdata;
                    m_pc <= m_pc + 16'd1;
                end
                EXECUTE: begin
                    if (m_taken()) m_pc <= m_target();
                    else if (pc_wr_en) m_pc <= pc_wr_data;
                end
                MEMORY: begin
                    if (pc_wr_en) m_pc <= pc_wr_data;
                end
                default: ;
            endcase
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            check_bit("cmp_fetch_en", bus.fetch_en, state == FETCH);
            check("cmp_fetch_addr", bus.fetch_addr, m_pc);
            check("cmp_ir", ir, m_ir);
            check("cmp_pc", pc, m_pc);
            check_bit("cmp_branch_taken", branch_taken, m_taken());
            check("cmp_branch_target", branch_target, m_target());
        end
    end

    task automatic drive(input logic [1:0] s, input logic [15:0] rd, input logic [3:0] f,
                         input logic we, input logic [15:0] wd);
        state          = s;
        bus.mem_rdata  = rd;
        cc             = f;
        pc_wr_en       = we;
        pc_wr_data     = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        rst = 1'b1;
        drive(FETCH, 16'h0000, 4'h0, 1'b0, 16'h0000);
        #1;
        check("rst_pc", pc, 16'h0000);
        check("rst_ir", ir, 16'h0000);
        check_bit("rst_fetch_en", bus.fetch_en, 1'b1);
        check_bit("rst_branch_taken", branch_taken, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Sequential fetch.
        drive(FETCH, 16'h1234, 4'h0, 1'b0, 16'h0000);
        #1;
        check("seq_fetch_addr0", bus.fetch_addr, 16'h0000);
        tick();
        drive(EXECUTE, 16'hBEEF, 4'h0, 1'b0, 16'h0000);
        #1;
        check("seq_ir", ir, 16'h1234);
        check("seq_pc", pc, 16'h0001);
        check("seq_fetch_addr1", bus.fetch_addr, 16'h0001);
        check_bit("seq_exec_fetch_en", bus.fetch_en, 1'b0);
        tick();

        // Taken Bcc: EQ, offset -2, Z set.
        drive(MEMORY, 16'h0000, 4'h0, 1'b1, 16'h0010);
        tick();
        check("bcc_setup_pc", pc, 16'h0010);
        drive(FETCH, 16'hE7FE, 4'h0, 1'b0, 16'h0000);
        tick();
        check("bcc_pc_before", pc, 16'h0011);
        check("bcc_ir", ir, 16'hE7FE);
        drive(EXECUTE, 16'h0000, 4'b0100, 1'b0, 16'h0000);
        #1;
        check_bit("bcc_taken", branch_taken, 1'b1);
        check("bcc_target", branch_target, 16'h000F);
        tick();
        check("bcc_taken_pc", pc, 16'h000F);

        // Not-taken Bcc: same instruction, Z clear.
        drive(MEMORY, 16'h0000, 4'h0, 1'b1, 16'h0010);
        tick();
        drive(FETCH, 16'hE7FE, 4'h0, 1'b0, 16'h0000);
        tick();
        drive(EXECUTE, 16'h0000, 4'b0000, 1'b0, 16'h0000);
        #1;
        check_bit("bcc_not_taken", branch_taken, 1'b0);
        tick();
        check("bcc_not_taken_pc", pc, 16'h0011);

        // All conditions against all flag combinations.
        for (int c = 0; c < 16; c++) begin
            logic [15:0] mask;
            mask = cond_mask[c];
            drive(MEMORY, 16'h0000, 4'h0, 1'b1, 16'h0100);
            tick();
            drive(FETCH, {4'hE, 4'(c), 8'h01}, 4'h0, 1'b0, 16'h0000);
            tick();
            for (int f = 0; f < 16; f++) begin
                drive(EXECUTE, 16'h0000, 4'(f), 1'b0, 16'h0000);
                #1;
                check_bit($sformatf("cond%0d_cc%0d", c, f), branch_taken, mask[f]);
                tick();
            end
        end

        // Wrap-around on increment.
        drive(MEMORY, 16'h0000, 4'h0, 1'b1, 16'hFFFF);
        tick();
        drive(FETCH, 16'h0000, 4'h0, 1'b0, 16'h0000);
        tick();
        check("wrap_inc_pc", pc, 16'h0000);

        // Wrap-around on branch: AL, offset +0x7F from 0xFFF0.
        drive(MEMORY, 16'h0000, 4'h0, 1'b1, 16'hFFEF);
        tick();
        drive(FETCH, 16'hE07F, 4'h0, 1'b0, 16'h0000);
        tick();
        check("wrap_bcc_pc_before", pc, 16'hFFF0);
        drive(EXECUTE, 16'h0000, 4'h0, 1'b0, 16'h0000);
        #1;
        check("wrap_bcc_target", branch_target, 16'h006F);
        tick();
        check("wrap_bcc_pc", pc, 16'h006F);

        // PC writes in MEMORY, ignored in FETCH, beaten by a taken branch.
        drive(MEMORY, 16'h0000, 4'h0, 1'b1, 16'h0200);
        tick();
        check("pcwr_memory", pc, 16'h0200);
        drive(FETCH, 16'hE005, 4'h0, 1'b1, 16'h0300);
        tick();
        check("pcwr_fetch_ignored", pc, 16'h0201);
        drive(EXECUTE, 16'h0000, 4'h0, 1'b1, 16'h0300);
        #1;
        check_bit("pcwr_exec_taken", branch_taken, 1'b1);
        tick();
        check("pcwr_branch_wins", pc, 16'h0206);
        drive(FETCH, 16'h1111, 4'h0, 1'b0, 16'h0000);
        tick();
        drive(EXECUTE, 16'h5555, 4'h0, 1'b1, 16'h0400);
        tick();
        check("pcwr_exec_nonbcc", pc, 16'h0400);
        check("pcwr_ir_holds", ir, 16'h1111);
        drive(MEMORY, 16'h0000, 4'h0, 1'b0, 16'h0000);
        tick();
        check("pcwr_memory_hold", pc, 16'h0400);

        // Asynchronous reset between clock edges during EXECUTE.
        drive(EXECUTE, 16'h0000, 4'h0, 1'b0, 16'h0000);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_pc", pc, 16'h0000);
        check("async_rst_ir", ir, 16'h0000);
        #1;
        rst = 1'b0;
        tick();
        drive(FETCH, 16'h2222, 4'h0, 1'b0, 16'h0000);
        #1;
        check("post_rst_fetch_addr", bus.fetch_addr, 16'h0000);
        tick();
        check("post_rst_ir", ir, 16'h2222);
        check("post_rst_pc", pc, 16'h0001);

        // Illegal state holds everything and suppresses fetch and branch.
        drive(FETCH, 16'hE003, 4'h0, 1'b0, 16'h0000);
        tick();
        drive(2'b11, 16'hAAAA, 4'h0, 1'b1, 16'h0700);
        #1;
        check_bit("illegal_fetch_en", bus.fetch_en, 1'b0);
        check_bit("illegal_branch_taken", branch_taken, 1'b0);
        repeat (3) tick();
        check("illegal_pc", pc, 16'h0002);
        check("illegal_ir", ir, 16'hE003);

        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stump_fetch_unit.md
# stump_fetch_unit

Program-counter and instruction-register stage of the Stump processor. It fetches instructions while the control FSM is in FETCH and latches them into `ir`, which drives the FSM's next-state decision and the downstream decode. It also resolves conditional branches (Bcc) during EXECUTE and accepts PC writes from the datapath. It owns `pc`, `ir` and the branch decision; the FSM owns sequencing.

## Interface
- `RESET_PC`, default 16'h0000: value loaded into `pc` on reset.
- `clk`  input  1: system clock.
- `rst`  input  1: asynchronous, active-high reset.
- `state`  input  2: current FSM state; FETCH / EXECUTE / MEMORY shared constants.
- `mem_rdata`  input  16: instruction word returned from memory, valid in the same cycle as `fetch_en`.
- `cc`  input  4: condition flags {N,Z,V,C} from the CC register.
- `pc_wr_en`  input  1: datapath writes a result to R7/PC.
- `pc_wr_data`  input  16: value for that write.
- `fetch_en`  output  1: memory instruction read strobe.
- `fetch_addr`  output  16: instruction address.
- `ir`  output  16: instruction register.
- `pc`  output  16: program counter.
- `branch_taken`  output  1: Bcc in EXECUTE with its condition true.
- `branch_target`  output  16: `pc` + sign-extended `ir[7:0]`.

## Operation
- **Reset:**
  - `pc` = RESET_PC, `ir` = 16'h0000.
  - Combinational outputs follow from these values: `fetch_en` = 1 only if `state` = FETCH; `branch_taken` = 0.
- **FETCH:**
  - `fetch_en` = 1 and `fetch_addr` = `pc`, both combinational.
  - On the clock edge, `ir` <= `mem_rdata` and `pc` <= `pc` + 1.
  - `pc_wr_en` is ignored in FETCH.
- **EXECUTE:**
  - `ir` holds.
  - If `ir[15:13]` = BCC opcode (3'b111) and `cond_true(ir[11:8], cc)`: `branch_taken` = 1 and `pc` <= `branch_target`.
  - Otherwise, if `pc_wr_en`: `pc` <= `pc_wr_data`.
  - Otherwise `pc` holds.
  - `branch_taken` is 0 outside EXECUTE and for non-Bcc opcodes.
- **MEMORY:**
  - If `pc_wr_en` (load to R7): `pc` <= `pc_wr_data`. Otherwise hold.
  - `ir` holds.
- **Illegal `state` (2'b11):** all registers hold; `fetch_en` = 0; `branch_taken` = 0.
- **Priority in EXECUTE:** a taken branch beats `pc_wr_en`.
- **Conditions** (`ir[11:8]`):
  - 0 AL, 1 NV, 2 HI (!C&!Z), 3 LS (C|Z)
  - 4 CC (!C), 5 CS (C), 6 NE (!Z), 7 EQ (Z)
  - 8 VC (!V), 9 VS (V), A PL (!N), B MI (N)
  - C GE (N==V), D LT (N!=V), E GT (!Z&N==V), F LE (Z|N!=V)
- **Arithmetic:** all PC arithmetic is 16-bit modulo 2^16. 16'hFFFF + 1 = 16'h0000. Offset is sign-extended from bit 7. `branch_target` uses the already-incremented `pc`, i.e. the address of the Bcc plus 1 plus the offset.

## Timing
- Instruction latency: address presented in FETCH cycle n; `ir` valid from cycle n+1 (EXECUTE), in time for the FSM's EXECUTE decision.
- Branch resolves in a single EXECUTE cycle; the next FETCH (n+2) uses the new `pc`. There is no delay slot.
- `fetch_en`, `fetch_addr`, `branch_taken` and `branch_target` are combinational from registered state and inputs. `cc` must be stable during EXECUTE.
- Reset mid-instruction: `pc` and `ir` clear immediately, independent of `clk`. The first fetch after release uses RESET_PC.
- A `mem_rdata` change outside FETCH has no effect.

## Structure
- Shared definitions include (alongside FSM states):
  - state constants FETCH, EXECUTE, MEMORY;
  - opcode constants LDST, BCC;
  - the 16 condition-code constants;
  - flag bit indices N/Z/V/C.
- One combinational sub-module, `stump_cond_eval`: inputs `cond[3:0]`, `cc[3:0]`; output `true`. It is reusable by the verification model.
- Registers live in a single clocked process with asynchronous reset; next-PC is selected by a priority mux.

## Test plan
- **Reset then sequential fetch:** assert `rst`, release, drive FETCH/EXECUTE cycles with `mem_rdata` = 16'h1234 -> `fetch_addr` 0x0000 then 0x0001; `ir` = 16'h1234 in EXECUTE; `pc` = 0x0001.
- **Taken and not-taken Bcc:**
  - `ir` = 16'hE7FE (EQ, offset -2), `pc` = 0x0011, `cc` Z=1 -> `branch_taken` = 1, `pc` becomes 0x000F.
  - Same `ir` with Z=0 -> `pc` stays 0x0011.
- **All 16 conditions:** sweep `cc` over 0..15 for each `cond` -> `branch_taken` matches the table; AL always 1, NV always 0.
- **Wrap-around:**
  - `pc` = 0xFFFF in FETCH -> `pc` = 0x0000.
  - Bcc offset 0x7F from `pc` 0xFFF0 -> `pc` = 0x006F.
- **PC writes:**
  - `pc_wr_en` with `pc_wr_data` = 0x0200 in MEMORY -> `pc` = 0x0200.
  - Same in FETCH -> ignored, `pc` increments.
  - Taken Bcc with `pc_wr_en` = 1 in EXECUTE -> `branch_target` wins.
- **Async reset mid-EXECUTE and illegal state:**
  - `rst` pulse between clock edges -> `pc` = RESET_PC, `ir` = 0 immediately.
  - `state` = 2'b11 for 3 cycles -> `pc` and `ir` unchanged; `fetch_en` = 0.
